// File: rtl/csd_pkg.sv
// Shared constants for the instruction-memory subsystem: state encoding, opcodes, default sizes.
package csd_pkg;

    localparam int unsigned DEF_AW    = 16;
    localparam int unsigned DEF_DW    = 16;
    localparam int unsigned DEF_DEPTH = 191;

    localparam logic [15:0] NOP   = 16'd50;
    localparam logic [15:0] ENDOP = 16'd51;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        WIN_FETCH = 1'b0,
        WIN_LOAD  = 1'b1
    } winner_e;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; last_winner only moves on a tie, so uncontended grants never bias the next tie.
module rr_arb2
    import csd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_fetch,
    input  logic req_load,
    output logic gnt_fetch,
    output logic gnt_load
);

    winner_e last_winner;
    logic    tie;

    assign tie = en && req_fetch && req_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= WIN_LOAD;
        end else if (tie) begin
            last_winner <= (last_winner == WIN_LOAD) ? WIN_FETCH : WIN_LOAD;
        end
    end

    always_comb begin
        gnt_fetch = 1'b0;
        gnt_load  = 1'b0;
        if (tie) begin
            gnt_fetch = (last_winner == WIN_LOAD);
            gnt_load  = (last_winner == WIN_FETCH);
        end else if (en) begin
            gnt_fetch = req_fetch;
            gnt_load  = req_load;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between CPU fetch and the program loader (BOOT fill, then RUN).
// Build option IMEM_WPROT_EN: write-protect the memory once in RUN (loader never granted, request flagged).
module imem_port_arbiter
    import csd_pkg::*;
#(
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter logic [DW-1:0] NOP_WORD = DW'(NOP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_valid,
    output logic [DW-1:0] fetch_data,
    output logic          cpu_stall,
    input  logic          load_req,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          load_gnt,
    input  logic          load_done,
    output logic [AW-1:0] words_loaded,
    output logic          err_oor,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state, state_nxt;
    logic          arb_en, arb_fetch_gnt, arb_load_gnt;
    logic          load_req_arb, wprot_hit;
    logic          fetch_oor, load_oor;
    logic          fetch_oor_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    assign fetch_oor = !addr_in_range(32'(fetch_addr), DEPTH);
    assign load_oor  = !addr_in_range(32'(load_addr), DEPTH);
    assign arb_en    = (state == RUN) && !rst;
    assign cpu_stall = (state == BOOT);

`ifdef IMEM_WPROT_EN
    assign load_req_arb = 1'b0;
    assign wprot_hit    = (state == RUN) && load_req;
`else
    assign load_req_arb = load_req;
    assign wprot_hit    = 1'b0;
`endif

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .req_fetch (fetch_req),
        .req_load  (load_req_arb),
        .gnt_fetch (arb_fetch_gnt),
        .gnt_load  (arb_load_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grants; reset suppresses every grant.
    always_comb begin
        state_nxt = state;
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!rst) begin
            case (state)
                BOOT: begin
                    load_gnt = load_req;
                    if (load_done) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    fetch_gnt = arb_fetch_gnt;
                    load_gnt  = arb_load_gnt;
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    // Memory port follows the winner; idle cycles repeat the previous address as a harmless read.
    always_comb begin
        mem_write_en = 1'b0;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (fetch_gnt) begin
            mem_addr = fetch_addr;
        end else if (load_gnt) begin
            mem_addr     = load_addr;
            mem_wdata    = load_data;
            mem_write_en = !load_oor;
        end
    end

    assign fetch_data = !fetch_valid ? '0 : (fetch_oor_q ? NOP_WORD : mem_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            fetch_valid  <= 1'b0;
            fetch_oor_q  <= 1'b0;
            words_loaded <= '0;
            err_oor      <= 1'b0;
        end else begin
            addr_q      <= mem_addr;
            wdata_q     <= mem_wdata;
            fetch_valid <= fetch_gnt;
            fetch_oor_q <= fetch_gnt && fetch_oor;
            if (mem_write_en && (words_loaded != {AW{1'b1}})) begin
                words_loaded <= words_loaded + AW'(1);
            end
            if ((fetch_gnt && fetch_oor) || (load_gnt && load_oor) || wprot_hit) begin
                err_oor <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized bench for imem_port_arbiter: reference model predicts grants/counters, scoreboard checks fetched words.
`timescale 1ns/1ps
module tb_imem_port_arbiter;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 191;
    localparam logic [DW-1:0] NOPW = 16'd50;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req, fetch_gnt, fetch_valid, cpu_stall;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_data;
    logic          load_req, load_gnt, load_done;
    logic [AW-1:0] load_addr, words_loaded;
    logic [DW-1:0] load_data;
    logic          err_oor, mem_write_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit fg, lg;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_valid  (fetch_valid),
        .fetch_data   (fetch_data),
        .cpu_stall    (cpu_stall),
        .load_req     (load_req),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_gnt     (load_gnt),
        .load_done    (load_done),
        .words_loaded (words_loaded),
        .err_oor      (err_oor),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Instruction memory: single port, registered read.
    logic [DW-1:0] imem [DEPTH];
    always @(posedge clk) begin
        if (mem_write_en && (32'(mem_addr) < DEPTH)) imem[mem_addr] <= mem_wdata;
        mem_rdata <= (32'(mem_addr) < DEPTH) ? imem[mem_addr] : 16'hdead;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: intended behaviour in plain terms.
    typedef struct {
        logic [DW-1:0] data;
        int            c;
    } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_run       = 1'b0;
    bit            m_fetch_next = 1'b1;
    int unsigned   m_words     = 0;
    bit            m_err       = 1'b0;
    logic [AW-1:0] m_addr      = '0;

    always @(negedge clk) begin
        bit ef, el, lreq;
        logic [AW-1:0] ea;
        chk("cpu_stall", 32'(cpu_stall), 32'(!m_run));
        chk("words_loaded", 32'(words_loaded), m_words);
        chk("err_oor", 32'(err_oor), 32'(m_err));
        ef = 1'b0;
        el = 1'b0;
        if (!rst) begin
            if (!m_run) begin
                el = load_req;
            end else begin
`ifdef IMEM_WPROT_EN
                lreq = 1'b0;
`else
                lreq = load_req;
`endif
                if (fetch_req && lreq) begin
                    ef = m_fetch_next;
                    el = !m_fetch_next;
                end else begin
                    ef = fetch_req;
                    el = lreq;
                end
            end
        end
        ea = rst ? '0 : (ef ? fetch_addr : (el ? load_addr : m_addr));
        chk("fetch_gnt", 32'(fetch_gnt), 32'(ef));
        chk("load_gnt", 32'(load_gnt), 32'(el));
        chk("mem_write_en", 32'(mem_write_en), 32'(el && (32'(load_addr) < DEPTH)));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (el && (32'(load_addr) < DEPTH)) chk("mem_wdata", 32'(mem_wdata), 32'(load_data));
        if (rst) begin
            m_run        = 1'b0;
            m_fetch_next = 1'b1;
            m_words      = 0;
            m_err        = 1'b0;
            m_addr       = '0;
        end else begin
            if (ef) begin
                sb.push_back('{(32'(fetch_addr) < DEPTH) ? ref_mem[fetch_addr] : NOPW, cyc});
                if (32'(fetch_addr) >= DEPTH) m_err = 1'b1;
            end
            if (el) begin
                if (32'(load_addr) < DEPTH) begin
                    ref_mem[load_addr] = load_data;
                    if (m_words < 65535) m_words++;
                end else begin
                    m_err = 1'b1;
                end
            end
`ifdef IMEM_WPROT_EN
            if (m_run && load_req) m_err = 1'b1;
`endif
            if (m_run && ef && el) m_fetch_next = 1'b0;
            if (m_run && fetch_req && load_req && el) m_fetch_next = 1'b1;
            if (m_run && fetch_req && load_req && ef) m_fetch_next = 1'b0;
            m_addr = ea;
            if (!m_run && load_done) m_run = 1'b1;
        end
    end

    // Scoreboard monitor: every granted fetch must return exactly one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (fetch_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fetch_valid_unexpected cycle=%0d got=1 want=0", cyc);
            end else begin
                e = sb.pop_front();
                chk("fetch_data", 32'(fetch_data), 32'(e.data));
                chk("fetch_latency", 32'(cyc - e.c), 32'd1);
            end
        end else if (sb.size() > 0 && sb[0].c < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL fetch_valid_missing cycle=%0d got=0 want=1 (granted cycle %0d)", cyc, e.c);
        end
    end

    task automatic tick();
        @(negedge clk);
        fg = fetch_gnt;
        lg = load_gnt;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 9) == 0) ? AW'($urandom_range(191, 300)) : AW'($urandom_range(0, 190));
    endfunction

    task automatic boot_fill(input int n);
        for (int i = 0; i < n; i++) begin
            load_req  = 1'b1;
            load_addr = AW'(i);
            load_data = (i == 0) ? 16'd38 : (i == 1) ? 16'd257 : (i == 2) ? 16'd9 : DW'($urandom);
            load_done = (i == n - 1);
            tick();
        end
        load_req  = 1'b0;
        load_done = 1'b0;
    endtask

    initial begin
        int seq;
        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        load_req = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
        repeat (3) tick();
        chk("reset_fetch_valid", 32'(fetch_valid), 0);
        chk("reset_mem_wdata", 32'(mem_wdata), 0);
        rst = 1'b0;

        // Boot fill with a fetch waiting the whole time; it may only be served in RUN.
        fetch_req  = 1'b1;
        fetch_addr = AW'(5);
        boot_fill(DEPTH);
        chk("boot_words", 32'(words_loaded), DEPTH);
        chk("boot_stall_fall", 32'(cpu_stall), 0);
        tick();
        chk("first_run_fetch", 32'(fg), 1);
        fetch_req = 1'b0;
        tick();

        // Back-to-back fetch stream
        for (int i = 0; i < 3; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = AW'(i);
            tick();
        end
        fetch_req = 1'b0;
        tick();
        tick();

        // Contention: both held four cycles
        fetch_req = 1'b1; fetch_addr = AW'(3);
        load_req  = 1'b1; load_addr  = AW'(10); load_data = DW'($urandom);
        for (int i = 0; i < 4; i++) begin
            tick();
            seq = fg ? 1 : (lg ? 2 : 0);
`ifdef IMEM_WPROT_EN
            chk("contention_order", 32'(seq), 1);
`else
            chk("contention_order", 32'(seq), (i % 2 == 0) ? 1 : 2);
`endif
            if (fg) fetch_addr = fetch_addr + AW'(1);
            if (lg) begin
                load_addr = load_addr + AW'(1);
                load_data = DW'($urandom);
            end
        end
        fetch_req = 1'b0;
        load_req  = 1'b0;
        tick();
        for (int i = 10; i < 13; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = AW'(i);
            tick();
        end
        fetch_req = 1'b0;
        tick();

        // Out of range fetch and write
        fetch_req = 1'b1; fetch_addr = AW'(200);
        tick();
        fetch_req = 1'b0;
        tick();
        chk("oor_err_sticky", 32'(err_oor), 1);
        load_req = 1'b1; load_addr = AW'(191); load_data = 16'h1234;
        tick();
        load_req = 1'b0;
        tick();

        // Random traffic with hold-until-grant requesters
        fg = 1'b0; lg = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!fetch_req || fg) begin
                fetch_req  = ($urandom_range(0, 2) != 0);
                fetch_addr = rand_addr();
            end
            if (!load_req || lg) begin
                load_req  = ($urandom_range(0, 2) == 0);
                load_addr = rand_addr();
                load_data = DW'($urandom);
            end
            load_done = ($urandom_range(0, 19) == 0);
            tick();
        end
        fetch_req = 1'b0; load_req = 1'b0; load_done = 1'b0;
        tick();

        // Reset in the cycle after a fetch grant
        fetch_req = 1'b1; fetch_addr = AW'(7);
        tick();
        chk("pre_reset_grant", 32'(fg), 1);
        fetch_req = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_fetch_valid", 32'(fetch_valid), 0);
        chk("rst_stall", 32'(cpu_stall), 1);
        chk("rst_words", 32'(words_loaded), 0);
        rst = 1'b0;

        // Short reboot and a few fetches
        boot_fill(4);
        for (int i = 0; i < 4; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = AW'(i);
            tick();
        end
        fetch_req = 1'b0;
        tick();
        tick();
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
